// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues single-outstanding requests to
// instruction memory and fills the IF/ID register that feeds decode.
module fetch_unit #(
  parameter int          ADDR_W   = 10,
  parameter int          INSTR_W  = 16,
  parameter int unsigned RESET_PC = 0
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_valid,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               stall_i,
  input  logic               flush_i,
  input  logic [ADDR_W-1:0]  flush_pc_i,
  output logic               if_id_valid,
  output logic [INSTR_W-1:0] if_id_instr,
  output logic [5:0]         if_id_opcode,
  output logic [ADDR_W-1:0]  if_id_pc,
  output logic [ADDR_W-1:0]  pc_o,
  output logic [1:0]         dbg_state_o
);

  localparam logic [5:0]         NOP      = 6'b000101;
  localparam logic [INSTR_W-1:0] NOP_WORD = {NOP, {(INSTR_W-6){1'b0}}};
  localparam logic [ADDR_W-1:0]  RST_PC   = ADDR_W'(RESET_PC);

  // Memory handshake: imem_req is a one-cycle pulse carrying imem_addr; the
  // matching imem_valid strobe arrives one or more cycles later, and only one
  // request is ever outstanding. Decode back-pressures with stall_i.
  typedef enum logic [1:0] {S_FETCH, S_WAIT, S_HOLD, S_DRAIN} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic [INSTR_W-1:0]  buf_instr_q, buf_instr_d;
  logic [ADDR_W-1:0]   buf_pc_q, buf_pc_d;
  logic                if_valid_q, if_valid_d;
  logic [INSTR_W-1:0]  if_instr_q, if_instr_d;
  logic [ADDR_W-1:0]   if_pc_q, if_pc_d;
  logic                req_c;
  logic                load_c;
  logic [INSTR_W-1:0]  load_instr_c;
  logic [ADDR_W-1:0]   load_pc_c;

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    buf_instr_d  = buf_instr_q;
    buf_pc_d     = buf_pc_q;
    req_c        = 1'b0;
    load_c       = 1'b0;
    load_instr_c = imem_rdata;
    load_pc_c    = pc_q;

    case (state_q)
      S_FETCH: begin
        req_c   = 1'b1;
        state_d = flush_i ? S_DRAIN : S_WAIT;
      end
      S_WAIT: begin
        if (flush_i) begin
          state_d = imem_valid ? S_FETCH : S_DRAIN;
        end else if (imem_valid) begin
          if (!stall_i) begin
            load_c  = 1'b1;
            pc_d    = pc_q + ADDR_W'(1);
            state_d = S_FETCH;
          end else begin
            buf_instr_d = imem_rdata;
            buf_pc_d    = pc_q;
            state_d     = S_HOLD;
          end
        end
      end
      S_HOLD: begin
        if (flush_i) begin
          state_d = S_FETCH;
        end else if (!stall_i) begin
          load_c       = 1'b1;
          load_instr_c = buf_instr_q;
          load_pc_c    = buf_pc_q;
          pc_d         = pc_q + ADDR_W'(1);
          state_d      = S_FETCH;
        end
      end
      // The response being drained also satisfies a flush that lands on it.
      S_DRAIN: begin
        if (imem_valid) state_d = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase

    if (flush_i) pc_d = flush_pc_i;
  end

  always_comb begin
    if_valid_d = if_valid_q;
    if_instr_d = if_instr_q;
    if_pc_d    = if_pc_q;
    if (flush_i) begin
      if_valid_d = 1'b0;
    end else if (load_c) begin
      if_valid_d = 1'b1;
      if_instr_d = load_instr_c;
      if_pc_d    = load_pc_c;
    end else if (!stall_i) begin
      if_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_FETCH;
      pc_q        <= RST_PC;
      buf_instr_q <= '0;
      buf_pc_q    <= '0;
      if_valid_q  <= 1'b0;
      if_instr_q  <= NOP_WORD;
      if_pc_q     <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      buf_instr_q <= buf_instr_d;
      buf_pc_q    <= buf_pc_d;
      if_valid_q  <= if_valid_d;
      if_instr_q  <= if_instr_d;
      if_pc_q     <= if_pc_d;
    end
  end

  // Reset parks the FSM in FETCH, so the request is gated until reset lifts.
  assign imem_req     = req_c & rst_n;
  assign imem_addr    = pc_q;
  assign if_id_valid  = if_valid_q;
  assign if_id_instr  = if_instr_q;
  assign if_id_opcode = if_valid_q ? if_instr_q[INSTR_W-1 -: 6] : NOP;
  assign if_id_pc     = if_pc_q;
  assign pc_o         = pc_q;
  assign dbg_state_o  = state_q;

endmodule
